// File: rtl/gray_step_sched_pkg.sv
// Shared constants for the Gray-stepper scheduler: FSM encoding, Gray landmarks, step function.
package gray_step_sched_pkg;

  localparam int unsigned ST_W = 2;
  localparam logic [ST_W-1:0] ST_IDLE = 2'd0;
  localparam logic [ST_W-1:0] ST_RUN  = 2'd1;
  localparam logic [ST_W-1:0] ST_DONE = 2'd2;

  localparam int unsigned GRAY_W = 3;
  localparam logic [GRAY_W-1:0] GRAY_WRAP_FROM = 3'b100;
  localparam logic [GRAY_W-1:0] GRAY_ZERO      = 3'b000;

  // One step along 000>001>011>010>110>111>101>100>000
  function automatic logic [GRAY_W-1:0] gray_next(input logic [GRAY_W-1:0] g);
    logic [GRAY_W-1:0] n;
    case (g)
      3'b000:  n = 3'b001;
      3'b001:  n = 3'b011;
      3'b011:  n = 3'b010;
      3'b010:  n = 3'b110;
      3'b110:  n = 3'b111;
      3'b111:  n = 3'b101;
      3'b101:  n = 3'b100;
      default: n = 3'b000;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/gray_step_sched_core.sv
// 3-bit Gray stepper; Wrap flags the step that is about to roll 100 over to 000.
module gray_seq_core
  import gray_step_sched_pkg::*;
(
  input  logic              Clk,
  input  logic              Reset,
  input  logic              En,
  output logic [GRAY_W-1:0] Q,
  output logic              Wrap
);

  always_ff @(posedge Clk) begin
    if (Reset) begin
      Q <= GRAY_ZERO;
    end else if (En) begin
      Q <= gray_next(Q);
    end
  end

  // Combinational so the owner can capture the wrap on the very edge it happens
  assign Wrap = En && (Q == GRAY_WRAP_FROM);

endmodule

// File: rtl/gray_step_sched.sv
// Round-robin owner arbitration for a single shared Gray stepper, with sticky wrap flag.
module gray_step_sched
  import gray_step_sched_pkg::*;
#(
  parameter int unsigned N_REQ  = 4,
  parameter int unsigned STEP_W = 4
) (
  input  logic                      Clk,
  input  logic                      Reset,
  input  logic [N_REQ-1:0]          Req,
  input  logic [N_REQ*STEP_W-1:0]   StepCnt,
  input  logic                      ClrOvf,
  output logic [N_REQ-1:0]          Grant,
  output logic                      Busy,
  output logic                      Done,
  output logic                      Abort,
  output logic [2:0]                DoneId,
  output logic [GRAY_W-1:0]         GrayOut,
  output logic                      Overflow
);

  localparam int unsigned IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  logic [ST_W-1:0]   state_q, state_d;
  logic [IDX_W-1:0]  ptr_q, ptr_d;
  logic [IDX_W-1:0]  win_q, win_d;
  logic [STEP_W-1:0] rem_q, rem_d;
  logic              aborted_q, aborted_d;
  logic [N_REQ-1:0]  grant_q, grant_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              abort_q, abort_d;
  logic [2:0]        doneid_q, doneid_d;
  logic              ovf_q, ovf_d;

  logic              en_c;
  logic              wrap_c;
  logic [IDX_W-1:0]  pick_c;
  logic [STEP_W-1:0] pick_cnt_c;
  logic [STEP_W-1:0] cnt_a [N_REQ];

  // First requester at or after ptr, wrapping modulo N_REQ
  function automatic logic [IDX_W-1:0] rr_pick(input logic [N_REQ-1:0] req,
                                               input logic [IDX_W-1:0] ptr);
    logic [IDX_W-1:0] sel;
    logic             found;
    int unsigned      j;
    sel   = '0;
    found = 1'b0;
    for (int unsigned k = 0; k < N_REQ; k++) begin
      j = (32'(ptr) + k) % N_REQ;
      if (!found && req[IDX_W'(j)]) begin
        sel   = IDX_W'(j);
        found = 1'b1;
      end
    end
    return sel;
  endfunction

  always_comb begin
    for (int i = 0; i < N_REQ; i++) begin
      cnt_a[i] = StepCnt[i*STEP_W +: STEP_W];
    end
  end

  assign pick_c     = rr_pick(Req, ptr_q);
  assign pick_cnt_c = cnt_a[pick_c];

  gray_seq_core u_core (
    .Clk   (Clk),
    .Reset (Reset),
    .En    (en_c),
    .Q     (GrayOut),
    .Wrap  (wrap_c)
  );

  // Next-state, stepper enable and next values of all registered outputs
  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    win_d     = win_q;
    rem_d     = rem_q;
    aborted_d = aborted_q;
    grant_d   = grant_q;
    done_d    = 1'b0;
    abort_d   = 1'b0;
    doneid_d  = 3'd0;
    en_c      = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (|Req) begin
          win_d     = pick_c;
          rem_d     = pick_cnt_c;
          aborted_d = 1'b0;
          if (pick_cnt_c == '0) begin
            state_d = ST_DONE;
            grant_d = '0;
          end else begin
            state_d = ST_RUN;
            grant_d = N_REQ'(1) << pick_c;
          end
        end
      end
      ST_RUN: begin
        if (Req[win_q]) begin
          en_c  = 1'b1;
          rem_d = rem_q - STEP_W'(1);
          if (rem_q == STEP_W'(1)) begin
            state_d = ST_DONE;
            grant_d = '0;
          end
        end else begin
          state_d   = ST_DONE;
          aborted_d = 1'b1;
          grant_d   = '0;
        end
      end
      ST_DONE: begin
        done_d   = 1'b1;
        abort_d  = aborted_q;
        doneid_d = 3'(win_q);
        ptr_d    = (win_q == IDX_W'(N_REQ - 1)) ? '0 : win_q + IDX_W'(1);
        state_d  = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
        grant_d = '0;
      end
    endcase

    busy_d = (state_d == ST_RUN) || (state_d == ST_DONE);
    // A wrap on the same edge as ClrOvf keeps the flag set
    ovf_d  = wrap_c ? 1'b1 : (ClrOvf ? 1'b0 : ovf_q);
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q   <= ST_IDLE;
      ptr_q     <= '0;
      win_q     <= '0;
      rem_q     <= '0;
      aborted_q <= 1'b0;
      grant_q   <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      abort_q   <= 1'b0;
      doneid_q  <= 3'd0;
      ovf_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      win_q     <= win_d;
      rem_q     <= rem_d;
      aborted_q <= aborted_d;
      grant_q   <= grant_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      abort_q   <= abort_d;
      doneid_q  <= doneid_d;
      ovf_q     <= ovf_d;
    end
  end

  assign Grant    = grant_q;
  assign Busy     = busy_q;
  assign Done     = done_q;
  assign Abort    = abort_q;
  assign DoneId   = doneid_q;
  assign Overflow = ovf_q;

endmodule
